// File: rtl/pwm_pattern_sequencer_pkg.sv
// Shared note codes, state encoding and pitch table
// for the PWM pattern sequencer.
package pwm_pattern_sequencer_pkg;

    localparam int NOTE_W = 6;

    // Code 1 is C2; each code step is one semitone.
    localparam logic [NOTE_W-1:0] NOTE_RST = 6'd0;
    localparam logic [NOTE_W-1:0] NOTE_C2  = 6'd1;
    localparam logic [NOTE_W-1:0] NOTE_C4  = 6'd25;
    localparam logic [NOTE_W-1:0] NOTE_D4  = 6'd27;
    localparam logic [NOTE_W-1:0] NOTE_E4  = 6'd29;
    localparam logic [NOTE_W-1:0] NOTE_G4  = 6'd32;
    localparam logic [NOTE_W-1:0] NOTE_A4  = 6'd34;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Phase increments for C7..B7 with a 32-bit accumulator at 25 MHz.
    function automatic logic [31:0] top_octave_delta(input logic [3:0] pc);
        logic [31:0] d;
        case (pc)
            4'd0:    d = 32'd359576;
            4'd1:    d = 32'd380957;
            4'd2:    d = 32'd403610;
            4'd3:    d = 32'd427610;
            4'd4:    d = 32'd453037;
            4'd5:    d = 32'd479976;
            4'd6:    d = 32'd508516;
            4'd7:    d = 32'd538754;
            4'd8:    d = 32'd570791;
            4'd9:    d = 32'd604731;
            4'd10:   d = 32'd640691;
            4'd11:   d = 32'd678788;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_pattern_sequencer_note_table.sv
// Note code to phase increment; lower octaves are
// derived by halving the top-octave value.
module note_table
    import pwm_pattern_sequencer_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [31:0]       phase_delta
);

    logic [NOTE_W-1:0] semi;
    logic [2:0]        oct;
    logic [3:0]        pc;
    logic [31:0]       top;

    always_comb begin
        semi = note - 6'd1;
        oct  = 3'(semi / 6'd12);
        pc   = 4'(semi % 6'd12);
        top  = top_octave_delta(pc);
        if (note == NOTE_RST) begin
            phase_delta = '0;
        end else begin
            phase_delta = top >> (3'd5 - oct);
        end
    end

endmodule

// File: rtl/pwm_pattern_sequencer.sv
// Plays a stored list of {note, length, last} entries,
// one tick-quantised note at a time, with optional looping.
module pwm_pattern_sequencer
    import pwm_pattern_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 2_083_333,
    parameter int DEPTH       = 16,
    parameter int LEN_W       = 5,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [NOTE_W-1:0]        i_wr_note,
    input  logic [LEN_W-1:0]         i_wr_len,
    input  logic                     i_wr_last,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_loop,
    output logic [NOTE_W-1:0]        o_note,
    output logic                     o_note_valid,
    output logic                     o_gate,
    output logic [31:0]              o_phase_delta,
    output logic [$clog2(DEPTH)-1:0] o_index,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [NOTE_W-1:0] mem_note [DEPTH];
    logic [LEN_W-1:0]  mem_len  [DEPTH];
    logic              mem_last [DEPTH];

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q;
    logic [LEN_W-1:0]  lcnt_q;
    logic [AW-1:0]     idx_q;
    logic [NOTE_W-1:0] note_q;
    logic [LEN_W-1:0]  len_q;
    logic              last_q;
    logic              valid_q;
    logic              done_q;

    logic              tick_end;
    logic              note_end;
    logic              fetch;
    logic              done_d;
    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     next_idx;

    assign tick_end = (tick_q == TW'(TICK_CYCLES - 1));
    assign note_end = tick_end && (lcnt_q == len_q);
    assign next_idx = (last_q || idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch     = 1'b0;
        fetch_idx = '0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = PLAY;
                    fetch   = 1'b1;
                end
            end
            PLAY: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (note_end) begin
                    if (last_q && !i_loop) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        fetch     = 1'b1;
                        fetch_idx = next_idx;
                    end
                end
            end
        endcase
    end

    // Storage writes land after the same-edge fetch reads the old entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_note[i] <= NOTE_RST;
                mem_len[i]  <= '0;
                mem_last[i] <= 1'b1;
            end
        end else if (i_wr_en) begin
            mem_note[i_wr_addr] <= i_wr_note;
            mem_len[i_wr_addr]  <= i_wr_len;
            mem_last[i_wr_addr] <= i_wr_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_q  <= '0;
            lcnt_q  <= '0;
            idx_q   <= '0;
            note_q  <= NOTE_RST;
            len_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= fetch;
            done_q  <= done_d;
            if (fetch) begin
                idx_q  <= fetch_idx;
                note_q <= mem_note[fetch_idx];
                len_q  <= mem_len[fetch_idx];
                last_q <= mem_last[fetch_idx];
                tick_q <= '0;
                lcnt_q <= '0;
            end else if (state_d == IDLE) begin
                idx_q  <= '0;
                note_q <= NOTE_RST;
                len_q  <= '0;
                last_q <= 1'b0;
                tick_q <= '0;
                lcnt_q <= '0;
            end else if (tick_end) begin
                tick_q <= '0;
                lcnt_q <= lcnt_q + 1'b1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    note_table u_note_table (
        .note        (note_q),
        .phase_delta (o_phase_delta)
    );

    assign o_note       = note_q;
    assign o_note_valid = valid_q;
    assign o_index      = idx_q;
    assign o_busy       = (state_q == PLAY);
    assign o_done       = done_q;
    assign o_gate       = (state_q == PLAY) && (note_q != NOTE_RST)
                          && !((lcnt_q == len_q)
                          && (32'(tick_q) >= 32'(TICK_CYCLES - GAP_CYCLES)));

endmodule
